// File: rtl/localbus_pkg.sv
// Shared types and constants for the two-master local-bus arbiter.
package localbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } lb_state_t;

  localparam int LB_NUM_MASTERS = 2;

endpackage

// File: rtl/lib_rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the master that did
// not win last time is chosen; a lone requester always wins.
module lib_rr_pick2
  import localbus_pkg::*;
(
  input  logic [LB_NUM_MASTERS-1:0] req,
  input  logic                      rr_last,
  output logic                      valid,
  output logic                      winner
);

  // Winner selection from the request vector and the last-served index.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~rr_last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/lib_localbus_arb.sv
// Two-master round-robin arbiter in front of the register-map local bus.
// Every output is a flop; strobes and write acks are loaded in the IDLE
// cycle that picks the winner so they appear during ISSUE.
module lib_localbus_arb
  import localbus_pkg::*;
#(
  parameter int AXI_AW     = 12,
  parameter int AXI_DW     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AXI_AW-1:0] m0_addr,
  input  logic [AXI_DW-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [AXI_DW-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AXI_AW-1:0] m1_addr,
  input  logic [AXI_DW-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [AXI_DW-1:0] m1_rdata,
  output logic              lb_wen,
  output logic              lb_ren,
  output logic [AXI_AW-1:0] lb_addr,
  output logic [AXI_DW-1:0] lb_wdata,
  input  logic [AXI_DW-1:0] lb_rdata
);

  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RD_LATENCY - 1);

  lb_state_t         state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lb_wen_q, lb_wen_d;
  logic              lb_ren_q, lb_ren_d;
  logic [AXI_AW-1:0] lb_addr_q, lb_addr_d;
  logic [AXI_DW-1:0] lb_wdata_q, lb_wdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [AXI_DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [AXI_DW-1:0] m1_rdata_q, m1_rdata_d;
  logic              pick_valid;
  logic              pick_winner;

  lib_rr_pick2 u_pick (
    .req     ({m1_req, m0_req}),
    .rr_last (rr_last_q),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  // Next-state and output logic; strobes and acks default to idle each cycle.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    lb_wen_d   = 1'b0;
    lb_ren_d   = 1'b0;
    lb_addr_d  = lb_addr_q;
    lb_wdata_d = lb_wdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d      = pick_winner;
          rr_last_d  = pick_winner;
          we_d       = pick_winner ? m1_we    : m0_we;
          lb_addr_d  = pick_winner ? m1_addr  : m0_addr;
          lb_wdata_d = pick_winner ? m1_wdata : m0_wdata;
          lb_wen_d   = we_d;
          lb_ren_d   = ~we_d;
          // A write completes in the strobe cycle, so its ack rides along.
          m0_ack_d   = we_d & ~pick_winner;
          m1_ack_d   = we_d & pick_winner;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          if (win_q) begin
            m1_rdata_d = lb_rdata;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = lb_rdata;
            m0_ack_d   = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      lb_wen_q   <= 1'b0;
      lb_ren_q   <= 1'b0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      lb_wen_q   <= lb_wen_d;
      lb_ren_q   <= lb_ren_d;
      lb_addr_q  <= lb_addr_d;
      lb_wdata_q <= lb_wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign lb_wen   = lb_wen_q;
  assign lb_ren   = lb_ren_q;
  assign lb_addr  = lb_addr_q;
  assign lb_wdata = lb_wdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_lib_localbus_arb.sv
// Bench for lib_localbus_arb: a default-latency instance and a RD_LATENCY=3
// instance, each fronted by a small register-map read model.
module tb_lib_localbus_arb;

  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [AW-1:0] m0_addr, m1_addr, lb_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, lb_wdata, lb_rdata;
  logic          lb_wen, lb_ren;

  logic          t_m0_req, t_m0_we, t_m0_ack, t_m1_req, t_m1_we, t_m1_ack;
  logic [AW-1:0] t_m0_addr, t_m1_addr, t_lb_addr;
  logic [DW-1:0] t_m0_wdata, t_m1_wdata, t_m0_rdata, t_m1_rdata, t_lb_wdata, t_lb_rdata;
  logic          t_lb_wen, t_lb_ren;

  lib_localbus_arb dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .lb_wen(lb_wen), .lb_ren(lb_ren), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .lb_rdata(lb_rdata)
  );

  lib_localbus_arb #(.RD_LATENCY(3)) dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .m0_req(t_m0_req), .m0_we(t_m0_we), .m0_addr(t_m0_addr), .m0_wdata(t_m0_wdata),
    .m0_ack(t_m0_ack), .m0_rdata(t_m0_rdata),
    .m1_req(t_m1_req), .m1_we(t_m1_we), .m1_addr(t_m1_addr), .m1_wdata(t_m1_wdata),
    .m1_ack(t_m1_ack), .m1_rdata(t_m1_rdata),
    .lb_wen(t_lb_wen), .lb_ren(t_lb_ren), .lb_addr(t_lb_addr), .lb_wdata(t_lb_wdata),
    .lb_rdata(t_lb_rdata)
  );

  // Register-map contents seen by reads.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      12'h020: return 32'hDEAD_BEEF;
      12'h030: return 32'h1234_5678;
      default: return {20'hA5A5A, a};
    endcase
  endfunction

  // Read models: valid data RD_LATENCY cycles after the strobe, noise otherwise.
  logic [DW-1:0] rd_pipe;
  logic [DW-1:0] t_pipe0, t_pipe1, t_pipe2;
  always @(posedge clk) begin
    rd_pipe <= lb_ren ? rom(lb_addr) : $urandom();
    t_pipe0 <= t_lb_ren ? rom(t_lb_addr) : $urandom();
    t_pipe1 <= t_pipe0 ^ (t_lb_ren ? 32'h0 : 32'h0);
    t_pipe2 <= t_pipe1;
  end
  assign lb_rdata   = rd_pipe;
  assign t_lb_rdata = t_pipe2;

  typedef struct {
    int            m;
    int            cyc;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t strb_q[$];
  ev_t ack_q[$];
  int  chk_cnt  = 0;
  int  pass_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the strobe and ack a request is expected to produce.
  task automatic push(input int m, input int cs, input int ca, input logic rd,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.m = m; e.cyc = cs; e.rd = rd; e.addr = a; e.data = d;
    strb_q.push_back(e);
    e.cyc = ca;
    ack_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if ({lb_wen, lb_ren, lb_addr, lb_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata} !== '0)
      $display("FAIL reset_outs: got wen=%b ren=%b addr=%h wdata=%h ack=%b%b rd0=%h rd1=%h, expected all 0",
               lb_wen, lb_ren, lb_addr, lb_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({t_lb_wen, t_lb_ren, t_lb_addr, t_lb_wdata, t_m0_ack, t_m1_ack, t_m0_rdata, t_m1_rdata} !== '0)
      $display("FAIL reset_outs_lat3: got wen=%b ren=%b addr=%h ack=%b%b, expected all 0",
               t_lb_wen, t_lb_ren, t_lb_addr, t_m0_ack, t_m1_ack);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++;
      if ({lb_wen, lb_ren, m0_ack, m1_ack} !== 4'b0)
        $display("FAIL reset_idle: got wen=%b ren=%b ack=%b%b with no request, expected 0",
                 lb_wen, lb_ren, m0_ack, m1_ack);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_single();
    ev_t e;
    m0_we = 1'b1; m0_addr = 12'h010; m0_wdata = 32'h0000_0001; m0_req = 1'b1;
    push(0, 1, 1, 1'b0, 12'h010, 32'h0000_0001);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (lb_wen || lb_ren) begin
        chk_cnt++;
        if (strb_q.size() == 0) $display("FAIL wr_strobe: got strobe cyc=%0d addr=%h, expected none", c, lb_addr);
        else begin
          e = strb_q.pop_front();
          if (c != e.cyc || {lb_ren, lb_wen} !== {e.rd, !e.rd} || lb_addr !== e.addr || lb_wdata !== e.data)
            $display("FAIL wr_strobe: got cyc=%0d wen=%b ren=%b addr=%h wdata=%h, expected cyc=%0d write addr=%h wdata=%h",
                     c, lb_wen, lb_ren, lb_addr, lb_wdata, e.cyc, e.addr, e.data);
          else pass_cnt++;
        end
      end
      if (m0_ack || m1_ack) begin
        chk_cnt++;
        if (ack_q.size() == 0) $display("FAIL wr_ack: got ack %b%b cyc=%0d, expected none", m1_ack, m0_ack, c);
        else begin
          e = ack_q.pop_front();
          if ((m0_ack && m1_ack) || int'(m1_ack) != e.m || c != e.cyc)
            $display("FAIL wr_ack: got m1_ack=%b m0_ack=%b cyc=%0d, expected m%0d cyc=%0d", m1_ack, m0_ack, c, e.m, e.cyc);
          else pass_cnt++;
        end
        if (m0_ack) m0_req = 1'b0;
        if (m1_ack) m1_req = 1'b0;
      end
    end
    chk_cnt++;
    if (strb_q.size() + ack_q.size() != 0) begin
      $display("FAIL wr_missing: got %0d events outstanding, expected 0", strb_q.size() + ack_q.size());
      strb_q.delete(); ack_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_read_single();
    ev_t           e;
    int            om[3]  = '{1, 0, 1};
    logic          ord[3] = '{1'b1, 1'b1, 1'b0};
    logic [AW-1:0] oa[3]  = '{12'h020, 12'h070, 12'h024};
    logic [DW-1:0] exp0 = '0, exp1 = '0, robs, wd;
    for (int k = 0; k < 3; k++) begin
      wd = 32'h5555_0000 + k;
      if (om[k] == 0) begin m0_we = !ord[k]; m0_addr = oa[k]; m0_wdata = wd; m0_req = 1'b1; end
      else begin m1_we = !ord[k]; m1_addr = oa[k]; m1_wdata = wd; m1_req = 1'b1; end
      push(om[k], 1, ord[k] ? 3 : 1, ord[k], oa[k], ord[k] ? rom(oa[k]) : wd);
      if (ord[k] && om[k] == 0) exp0 = rom(oa[k]);
      if (ord[k] && om[k] == 1) exp1 = rom(oa[k]);
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (lb_wen || lb_ren) begin
          chk_cnt++;
          if (strb_q.size() == 0) $display("FAIL rd_strobe: got strobe cyc=%0d addr=%h, expected none", c, lb_addr);
          else begin
            e = strb_q.pop_front();
            if (c != e.cyc || {lb_ren, lb_wen} !== {e.rd, !e.rd} || lb_addr !== e.addr || (!e.rd && lb_wdata !== e.data))
              $display("FAIL rd_strobe: got cyc=%0d wen=%b ren=%b addr=%h wdata=%h, expected cyc=%0d rd=%b addr=%h",
                       c, lb_wen, lb_ren, lb_addr, lb_wdata, e.cyc, e.rd, e.addr);
            else pass_cnt++;
          end
        end
        if (m0_ack || m1_ack) begin
          chk_cnt++;
          robs = m1_ack ? m1_rdata : m0_rdata;
          if (ack_q.size() == 0) $display("FAIL rd_ack: got ack %b%b cyc=%0d, expected none", m1_ack, m0_ack, c);
          else begin
            e = ack_q.pop_front();
            if ((m0_ack && m1_ack) || int'(m1_ack) != e.m || c != e.cyc || (e.rd && robs !== e.data))
              $display("FAIL rd_ack: got m1_ack=%b m0_ack=%b cyc=%0d rdata=%h, expected m%0d cyc=%0d rdata=%h",
                       m1_ack, m0_ack, c, robs, e.m, e.cyc, e.data);
            else pass_cnt++;
          end
          if (m0_ack) m0_req = 1'b0;
          if (m1_ack) m1_req = 1'b0;
        end
      end
      chk_cnt++;
      if (strb_q.size() + ack_q.size() != 0) begin
        $display("FAIL rd_missing op%0d: got %0d events outstanding, expected 0", k, strb_q.size() + ack_q.size());
        strb_q.delete(); ack_q.delete();
      end else pass_cnt++;
      chk_cnt++;
      if (m0_rdata !== exp0 || m1_rdata !== exp1)
        $display("FAIL rdata_hold op%0d: got m0=%h m1=%h, expected m0=%h m1=%h", k, m0_rdata, m1_rdata, exp0, exp1);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous(input string tag);
    ev_t e;
    m0_we = 1'b1; m0_addr = 12'h040; m0_wdata = 32'h0000_0011;
    m1_we = 1'b1; m1_addr = 12'h044; m1_wdata = 32'h0000_0022;
    m0_req = 1'b1; m1_req = 1'b1;
    push(0, 1, 1, 1'b0, 12'h040, 32'h0000_0011);
    push(1, 3, 3, 1'b0, 12'h044, 32'h0000_0022);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (lb_wen || lb_ren) begin
        chk_cnt++;
        if (strb_q.size() == 0) $display("FAIL %s_strobe: got strobe cyc=%0d addr=%h, expected none", tag, c, lb_addr);
        else begin
          e = strb_q.pop_front();
          if (c != e.cyc || {lb_ren, lb_wen} !== 2'b01 || lb_addr !== e.addr || lb_wdata !== e.data)
            $display("FAIL %s_strobe: got cyc=%0d wen=%b ren=%b addr=%h wdata=%h, expected cyc=%0d addr=%h wdata=%h",
                     tag, c, lb_wen, lb_ren, lb_addr, lb_wdata, e.cyc, e.addr, e.data);
          else pass_cnt++;
        end
      end
      if (m0_ack || m1_ack) begin
        chk_cnt++;
        if (ack_q.size() == 0) $display("FAIL %s_ack: got ack %b%b cyc=%0d, expected none", tag, m1_ack, m0_ack, c);
        else begin
          e = ack_q.pop_front();
          if ((m0_ack && m1_ack) || int'(m1_ack) != e.m || c != e.cyc)
            $display("FAIL %s_ack: got m1_ack=%b m0_ack=%b cyc=%0d, expected m%0d cyc=%0d", tag, m1_ack, m0_ack, c, e.m, e.cyc);
          else pass_cnt++;
        end
        if (m0_ack) m0_req = 1'b0;
        if (m1_ack) m1_req = 1'b0;
      end
    end
    chk_cnt++;
    if (strb_q.size() + ack_q.size() != 0) begin
      $display("FAIL %s_missing: got %0d events outstanding, expected 0", tag, strb_q.size() + ack_q.size());
      strb_q.delete(); ack_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_saturation();
    ev_t e;
    int  nack = 0;
    do_reset();
    m0_we = 1'b1; m0_addr = 12'h050; m0_wdata = 32'h0000_0100;
    m1_we = 1'b1; m1_addr = 12'h054; m1_wdata = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 10; k++)
      push(k % 2, 2 * k + 1, 2 * k + 1, 1'b0, (k % 2) ? 12'h054 : 12'h050,
           ((k % 2) ? 32'h200 : 32'h100) + k / 2);
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (lb_wen || lb_ren) begin
        chk_cnt++;
        if (strb_q.size() == 0) $display("FAIL sat_strobe: got strobe cyc=%0d addr=%h, expected none", c, lb_addr);
        else begin
          e = strb_q.pop_front();
          if (c != e.cyc || {lb_ren, lb_wen} !== 2'b01 || lb_addr !== e.addr || lb_wdata !== e.data)
            $display("FAIL sat_strobe: got cyc=%0d wen=%b ren=%b addr=%h wdata=%h, expected cyc=%0d addr=%h wdata=%h",
                     c, lb_wen, lb_ren, lb_addr, lb_wdata, e.cyc, e.addr, e.data);
          else pass_cnt++;
        end
      end
      if (m0_ack || m1_ack) begin
        chk_cnt++;
        if (ack_q.size() == 0) $display("FAIL sat_ack: got ack %b%b cyc=%0d, expected none", m1_ack, m0_ack, c);
        else begin
          e = ack_q.pop_front();
          if ((m0_ack && m1_ack) || int'(m1_ack) != e.m || c != e.cyc)
            $display("FAIL sat_ack: got m1_ack=%b m0_ack=%b cyc=%0d, expected m%0d cyc=%0d", m1_ack, m0_ack, c, e.m, e.cyc);
          else pass_cnt++;
        end
        nack++;
        if (m0_ack) m0_wdata = m0_wdata + 1;
        if (m1_ack) m1_wdata = m1_wdata + 1;
        if (nack == 10) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    chk_cnt++;
    if (strb_q.size() + ack_q.size() != 0) begin
      $display("FAIL sat_missing: got %0d events outstanding, expected 0", strb_q.size() + ack_q.size());
      strb_q.delete(); ack_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_long_latency();
    ev_t e;
    do_reset();
    t_m0_we = 1'b0; t_m0_addr = 12'h030; t_m0_req = 1'b1;
    push(0, 1, 5, 1'b1, 12'h030, 32'h1234_5678);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (t_lb_wen || t_lb_ren) begin
        chk_cnt++;
        if (strb_q.size() == 0) $display("FAIL lat3_strobe: got strobe cyc=%0d addr=%h, expected none", c, t_lb_addr);
        else begin
          e = strb_q.pop_front();
          if (c != e.cyc || {t_lb_ren, t_lb_wen} !== 2'b10 || t_lb_addr !== e.addr)
            $display("FAIL lat3_strobe: got cyc=%0d wen=%b ren=%b addr=%h, expected cyc=%0d read addr=%h",
                     c, t_lb_wen, t_lb_ren, t_lb_addr, e.cyc, e.addr);
          else pass_cnt++;
        end
      end
      if (t_m0_ack || t_m1_ack) begin
        chk_cnt++;
        if (ack_q.size() == 0) $display("FAIL lat3_ack: got ack %b%b cyc=%0d, expected none", t_m1_ack, t_m0_ack, c);
        else begin
          e = ack_q.pop_front();
          if (t_m1_ack || c != e.cyc || t_m0_rdata !== e.data)
            $display("FAIL lat3_ack: got m1_ack=%b m0_ack=%b cyc=%0d rdata=%h, expected m0 cyc=%0d rdata=%h",
                     t_m1_ack, t_m0_ack, c, t_m0_rdata, e.cyc, e.data);
          else pass_cnt++;
        end
        t_m0_req = 1'b0;
      end
    end
    chk_cnt++;
    if (strb_q.size() + ack_q.size() != 0) begin
      $display("FAIL lat3_missing: got %0d events outstanding, expected 0", strb_q.size() + ack_q.size());
      strb_q.delete(); ack_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ev = 0;
    do_reset();
    m0_we = 1'b0; m0_addr = 12'h020; m0_req = 1'b1;
    tick();
    chk_cnt++;
    if (lb_ren !== 1'b1 || lb_addr !== 12'h020)
      $display("FAIL mid_issue: got ren=%b addr=%h, expected ren=1 addr=020", lb_ren, lb_addr);
    else pass_cnt++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({lb_wen, lb_ren, lb_addr, lb_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata} !== '0)
      $display("FAIL mid_reset_outs: got wen=%b ren=%b addr=%h ack=%b%b rd0=%h, expected all 0",
               lb_wen, lb_ren, lb_addr, m0_ack, m1_ack, m0_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      ev += int'(lb_wen) + int'(lb_ren) + int'(m0_ack) + int'(m1_ack);
    end
    chk_cnt++;
    if (ev != 0) $display("FAIL mid_quiet: got %0d strobe/ack events after release, expected 0", ev);
    else pass_cnt++;
    test_simultaneous("mid_rr");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {m0_req, m0_we, m1_req, m1_we} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    {t_m0_req, t_m0_we, t_m1_req, t_m1_we} = '0;
    t_m0_addr = '0; t_m1_addr = '0; t_m0_wdata = '0; t_m1_wdata = '0;
    test_reset();
    test_write_single();
    test_read_single();
    do_reset();
    test_simultaneous("sim");
    test_saturation();
    test_long_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
